// File: rtl/key_cmd_sched.sv
// key_cmd_sched: panel push-buttons -> queued one-shot commands.
// Each key is synchronised, debounced and edge-detected in its own lane;
// presses latch into pend[] and a round-robin scheduler offers one pending
// key at a time on a valid/ready handshake, with a guard gap after each
// accepted command.

module key_cmd_lane #(
    parameter int DEB_CYCLES = 1_000_000,
    parameter int CNT_W      = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_raw,
    output logic rise
);
    logic             meta;
    logic             sync;
    logic             stable;
    logic             stable_d;
    logic [CNT_W-1:0] cnt;

    // two-flop synchroniser for the asynchronous key level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            sync <= 1'b0;
        end else begin
            meta <= key_raw;
            sync <= meta;
        end
    end

    // accept a new level only after DEB_CYCLES consecutive disagreeing samples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable <= 1'b0;
            cnt    <= '0;
        end else if (sync == stable) begin
            cnt <= '0;
        end else if (cnt == CNT_W'(DEB_CYCLES - 1)) begin
            stable <= sync;
            cnt    <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // delayed copy of the debounced level for press detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stable_d <= 1'b0;
        else        stable_d <= stable;
    end

    // press only; release issues nothing
    assign rise = stable & ~stable_d;
endmodule

module key_cmd_sched #(
    parameter int N_KEYS     = 4,
    parameter int ID_W       = 2,
    parameter int DEB_CYCLES = 1_000_000,
    parameter int CNT_W      = 20,
    parameter int GAP_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_KEYS-1:0] key_io,
    output logic              cmd_valid,
    output logic [ID_W-1:0]   cmd_id,
    input  logic              cmd_ready,
    output logic [N_KEYS-1:0] pend,
    output logic              overrun
);
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;

    state_t            state;
    logic [ID_W-1:0]   last_grant;
    logic [ID_W-1:0]   grant;
    logic [GAP_W-1:0]  gap_cnt;
    logic [N_KEYS-1:0] rise;
    logic [N_KEYS-1:0] acc_mask;
    logic              acc;

    for (genvar i = 0; i < N_KEYS; i++) begin : g_lane
        key_cmd_lane #(
            .DEB_CYCLES(DEB_CYCLES),
            .CNT_W     (CNT_W)
        ) u_lane (
            .clk    (clk),
            .rst_n  (rst_n),
            .key_raw(key_io[i]),
            .rise   (rise[i])
        );
    end

    assign acc = cmd_valid & cmd_ready;

    // one-hot of the key whose command is being accepted this cycle
    always_comb begin
        acc_mask = '0;
        for (int i = 0; i < N_KEYS; i++)
            acc_mask[i] = acc && (cmd_id == ID_W'(i));
    end

    // round-robin pick: first pending key above last_grant, wrapping;
    // scanning downward lets the nearest candidate win
    always_comb begin
        logic [ID_W-1:0] idx;
        grant = '0;
        idx   = '0;
        for (int k = N_KEYS; k >= 1; k--) begin
            idx = ID_W'((int'(last_grant) + k) % N_KEYS);
            if (pend[idx]) grant = idx;
        end
    end

    // pend latches presses; a press on a key already pending (and not being
    // accepted right now) is dropped and flagged as overrun
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend    <= '0;
            overrun <= 1'b0;
        end else begin
            pend    <= rise | (pend & ~acc_mask);
            overrun <= |(rise & pend & ~acc_mask);
        end
    end

    // scheduler: offer, hold until accepted, then enforce the guard gap.
    // Loading GAP_CYCLES and leaving at 1 keeps the FSM in GAP for exactly
    // GAP_CYCLES cycles, giving GAP_CYCLES+2 between back-to-back accepts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cmd_valid  <= 1'b0;
            cmd_id     <= '0;
            last_grant <= ID_W'(N_KEYS - 1);
            gap_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|pend) begin
                        cmd_valid <= 1'b1;
                        cmd_id    <= grant;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (cmd_ready) begin
                        cmd_valid  <= 1'b0;
                        last_grant <= cmd_id;
                        if (GAP_CYCLES == 0) begin
                            state <= IDLE;
                        end else begin
                            state   <= GAP;
                            gap_cnt <= GAP_W'(GAP_CYCLES);
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt <= GAP_W'(1)) state   <= IDLE;
                    else                      gap_cnt <= gap_cnt - 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
